// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned ADDR_BITS   = 32;
    localparam int unsigned DATA_BITS   = 32;
    localparam int unsigned INDEX_BITS  = 6;
    localparam int unsigned OFFSET_BITS = 2;
    localparam int unsigned BYTE_BITS   = 2;
    localparam int unsigned TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS - BYTE_BITS;
    localparam int unsigned LINES       = 1 << INDEX_BITS;
    localparam int unsigned WORDS       = 1 << OFFSET_BITS;
    localparam int unsigned SLOT_BITS   = INDEX_BITS + OFFSET_BITS;
    localparam int unsigned WADDR_BITS  = ADDR_BITS - BYTE_BITS;

    typedef logic [DATA_BITS-1:0]   data_t;
    typedef logic [ADDR_BITS-1:0]   addr_t;
    typedef logic [TAG_BITS-1:0]    tag_t;
    typedef logic [INDEX_BITS-1:0]  idx_t;
    typedef logic [OFFSET_BITS-1:0] off_t;
    typedef logic [SLOT_BITS-1:0]   slot_t;
    typedef logic [WADDR_BITS-1:0]  waddr_t;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_FILL = 2'd1,
        IC_RESP = 2'd2
    } ic_state_t;

    // Word address viewed as tag / line index / word-in-line.
    typedef struct packed {
        tag_t tag;
        idx_t idx;
        off_t off;
    } pc_fields_t;

    function automatic pc_fields_t split_pc(input waddr_t waddr);
        return pc_fields_t'(waddr);
    endfunction

    function automatic addr_t word_addr(input tag_t tag, input idx_t idx, input off_t off);
        return {tag, idx, off, {BYTE_BITS{1'b0}}};
    endfunction

    function automatic slot_t make_slot(input idx_t idx, input off_t off);
        return {idx, off};
    endfunction

endpackage

// File: rtl/icache_store.sv
// Line storage: data words, tags and valid bits. Only valid bits are reset.
module icache_store
    import icache_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   data_we,
    input  slot_t  wr_slot,
    input  data_t  wr_data,
    input  logic   line_we,
    input  idx_t   line_idx,
    input  tag_t   line_tag,
    input  slot_t  rd_slot,
    output data_t  rd_data_c,
    input  idx_t   look_idx,
    output logic   look_valid_c,
    output tag_t   look_tag_c
);

    data_t             data_mem [LINES*WORDS];
    tag_t              tag_mem  [LINES];
    logic [LINES-1:0]  valid;

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[wr_slot] <= wr_data;
        end
        if (line_we) begin
            tag_mem[line_idx] <= line_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (line_we) begin
            valid[line_idx] <= 1'b1;
        end
    end

    assign rd_data_c    = data_mem[rd_slot];
    assign look_valid_c = valid[look_idx];
    assign look_tag_c   = tag_mem[look_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, in-order line fill on miss.
module icache
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_fetcher_flag,
    input  logic [31:0] in_fetcher_pc,
    output logic        out_fetcher_flag,
    output logic [31:0] out_fetcher_inst,
    input  logic        in_rob_xbp,
    output logic        out_mem_flag,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_flag,
    input  logic [31:0] in_mem_data
);

    localparam off_t LAST_WORD = off_t'(WORDS - 1);

    ic_state_t  state, state_next;
    logic       drop, drop_next;
    tag_t       tag_q, tag_next;
    idx_t       idx_q, idx_next;
    off_t       off_q, off_next;
    off_t       cnt_q, cnt_next;
    logic       fetch_flag_next;
    data_t      fetch_inst_next;
    logic       mem_flag_next;
    addr_t      mem_addr_next;
    logic       data_we_c, line_we_c;

    pc_fields_t req;
    slot_t      rd_slot;
    data_t      rd_data_c;
    logic       look_valid_c;
    tag_t       look_tag_c;
    logic       hit_c;
    logic       unused_pc_bits;

    assign req            = split_pc(in_fetcher_pc[ADDR_BITS-1:BYTE_BITS]);
    assign unused_pc_bits = ^in_fetcher_pc[BYTE_BITS-1:0];
    assign hit_c          = look_valid_c && (look_tag_c == req.tag);
    // Idle reads serve the lookup; otherwise the latched requested word is read.
    assign rd_slot        = (state == IC_IDLE) ? make_slot(req.idx, req.off)
                                               : make_slot(idx_q, off_q);

    icache_store u_store (
        .clk          (clk),
        .rst          (rst),
        .data_we      (data_we_c && rdy),
        .wr_slot      (make_slot(idx_q, cnt_q)),
        .wr_data      (in_mem_data),
        .line_we      (line_we_c && rdy),
        .line_idx     (idx_q),
        .line_tag     (tag_q),
        .rd_slot      (rd_slot),
        .rd_data_c    (rd_data_c),
        .look_idx     (req.idx),
        .look_valid_c (look_valid_c),
        .look_tag_c   (look_tag_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IC_IDLE;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next      = state;
        drop_next       = drop;
        tag_next        = tag_q;
        idx_next        = idx_q;
        off_next        = off_q;
        cnt_next        = cnt_q;
        fetch_flag_next = 1'b0;
        fetch_inst_next = out_fetcher_inst;
        mem_flag_next   = out_mem_flag;
        mem_addr_next   = out_mem_addr;
        data_we_c       = 1'b0;
        line_we_c       = 1'b0;

        unique case (state)
            IC_IDLE: begin
                if (in_fetcher_flag && !in_rob_xbp) begin
                    if (hit_c) begin
                        fetch_flag_next = 1'b1;
                        fetch_inst_next = rd_data_c;
                    end else begin
                        tag_next      = req.tag;
                        idx_next      = req.idx;
                        off_next      = req.off;
                        cnt_next      = off_t'(0);
                        mem_flag_next = 1'b1;
                        mem_addr_next = word_addr(req.tag, req.idx, off_t'(0));
                        state_next    = IC_FILL;
                    end
                end
            end
            IC_FILL: begin
                drop_next = drop | in_rob_xbp;
                if (!out_mem_flag) begin
                    mem_flag_next = 1'b1;
                    mem_addr_next = word_addr(tag_q, idx_q, cnt_q);
                end else if (in_mem_flag) begin
                    data_we_c     = 1'b1;
                    mem_flag_next = 1'b0;
                    if (cnt_q == LAST_WORD) begin
                        // Response goes out in the RESP cycle; last word bypasses the array.
                        line_we_c       = 1'b1;
                        state_next      = IC_RESP;
                        fetch_flag_next = !(drop | in_rob_xbp);
                        fetch_inst_next = (off_q == LAST_WORD) ? in_mem_data : rd_data_c;
                    end else begin
                        cnt_next = cnt_q + off_t'(1);
                    end
                end
            end
            IC_RESP: begin
                drop_next  = 1'b0;
                state_next = IC_IDLE;
            end
            default: begin
                state_next = IC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop             <= 1'b0;
            tag_q            <= '0;
            idx_q            <= '0;
            off_q            <= '0;
            cnt_q            <= '0;
            out_fetcher_flag <= 1'b0;
            out_fetcher_inst <= '0;
            out_mem_flag     <= 1'b0;
            out_mem_addr     <= '0;
        end else if (rdy) begin
            drop             <= drop_next;
            tag_q            <= tag_next;
            idx_q            <= idx_next;
            off_q            <= off_next;
            cnt_q            <= cnt_next;
            out_fetcher_flag <= fetch_flag_next;
            out_fetcher_inst <= fetch_inst_next;
            out_mem_flag     <= mem_flag_next;
            out_mem_addr     <= mem_addr_next;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a line-residency reference model.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_fetcher_flag;
    logic [31:0] in_fetcher_pc;
    logic        out_fetcher_flag;
    logic [31:0] out_fetcher_inst;
    logic        in_rob_xbp;
    logic        out_mem_flag;
    logic [31:0] out_mem_addr;
    logic        in_mem_flag;
    logic [31:0] in_mem_data;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: which 16-byte block each of the 64 lines holds.
    bit          mvalid [64];
    logic [21:0] mtag   [64];

    icache dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_fetcher_flag  (in_fetcher_flag),
        .in_fetcher_pc    (in_fetcher_pc),
        .out_fetcher_flag (out_fetcher_flag),
        .out_fetcher_inst (out_fetcher_inst),
        .in_rob_xbp       (in_rob_xbp),
        .out_mem_flag     (out_mem_flag),
        .out_mem_addr     (out_mem_addr),
        .in_mem_flag      (in_mem_flag),
        .in_mem_data      (in_mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] r;
        r = {a[15:0], a[31:16]};
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end
    endtask

    // One fetch; entered and left on a negedge. xbp_after: word after which a flush is pulsed.
    task automatic do_fetch(input logic [31:0] pc, input int xbp_after, input int stall);
        logic [31:0] base, exp_inst;
        logic [21:0] tag;
        int          idx, n;
        bit          hit, dropped;
        base     = {pc[31:4], 4'h0};
        tag      = pc[31:10];
        idx      = int'(pc[9:4]);
        hit      = mvalid[idx] && (mtag[idx] == tag);
        exp_inst = mem_word({pc[31:2], 2'b00});
        dropped  = 1'b0;

        in_fetcher_flag = 1'b1;
        in_fetcher_pc   = pc;
        @(negedge clk);
        in_fetcher_flag = 1'b0;
        in_fetcher_pc   = $urandom;

        if (hit) begin
            check_val("hit_flag", 32'(out_fetcher_flag), 32'd1);
            check_val("hit_inst", out_fetcher_inst, exp_inst);
            check_val("hit_no_mem", 32'(out_mem_flag), 32'd0);
            if (stall >= 0) begin
                rdy = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_val("stall_hit_flag", 32'(out_fetcher_flag), 32'd1);
                    check_val("stall_hit_inst", out_fetcher_inst, exp_inst);
                end
                rdy = 1'b1;
            end
            @(negedge clk);
            check_val("hit_pulse_end", 32'(out_fetcher_flag), 32'd0);
            return;
        end

        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (!out_mem_flag && n < 20) begin
                check_val("fill_no_resp", 32'(out_fetcher_flag), 32'd0);
                @(negedge clk);
                n++;
            end
            check_val("mem_req_seen", 32'(out_mem_flag), 32'd1);
            if (!out_mem_flag) return;
            check_val("mem_addr", out_mem_addr, base + 32'(4 * w));
            if (w == stall) begin
                rdy         = 1'b0;
                in_mem_flag = 1'b1;
                in_mem_data = 32'hDEAD_BEEF;
                repeat (5) begin
                    @(negedge clk);
                    in_mem_flag = 1'b0;
                    check_val("stall_mem_flag", 32'(out_mem_flag), 32'd1);
                    check_val("stall_mem_addr", out_mem_addr, base + 32'(4 * w));
                end
                rdy = 1'b1;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            in_mem_flag = 1'b1;
            in_mem_data = mem_word(base + 32'(4 * w));
            @(negedge clk);
            in_mem_flag = 1'b0;
            in_mem_data = $urandom;
            check_val("mem_flag_drop", 32'(out_mem_flag), 32'd0);
            if (w == xbp_after && w < 3) begin
                in_rob_xbp = 1'b1;
                dropped    = 1'b1;
                @(negedge clk);
                in_rob_xbp = 1'b0;
            end
        end

        check_val("resp_flag", 32'(out_fetcher_flag), dropped ? 32'd0 : 32'd1);
        if (!dropped) check_val("resp_inst", out_fetcher_inst, exp_inst);
        mvalid[idx] = 1'b1;
        mtag[idx]   = tag;
        @(negedge clk);
        check_val("resp_pulse_end", 32'(out_fetcher_flag), 32'd0);
        check_val("resp_no_mem", 32'(out_mem_flag), 32'd0);
    endtask

    // A request coinciding with a flush must be ignored entirely.
    task automatic req_with_xbp(input logic [31:0] pc);
        in_fetcher_flag = 1'b1;
        in_fetcher_pc   = pc;
        in_rob_xbp      = 1'b1;
        @(negedge clk);
        in_fetcher_flag = 1'b0;
        in_rob_xbp      = 1'b0;
        check_val("xbp_req_no_resp", 32'(out_fetcher_flag), 32'd0);
        check_val("xbp_req_no_mem", 32'(out_mem_flag), 32'd0);
        @(negedge clk);
        check_val("xbp_req_still_idle", 32'(out_mem_flag), 32'd0);
    endtask

    task automatic reset_mid_fill(input logic [31:0] pc);
        in_fetcher_flag = 1'b1;
        in_fetcher_pc   = pc;
        @(negedge clk);
        in_fetcher_flag = 1'b0;
        check_val("rmf_mem_req", 32'(out_mem_flag), 32'd1);
        check_val("rmf_addr0", out_mem_addr, {pc[31:4], 4'h0});
        in_mem_flag = 1'b1;
        in_mem_data = mem_word({pc[31:4], 4'h0});
        @(negedge clk);
        in_mem_flag = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rmf_fetch_flag", 32'(out_fetcher_flag), 32'd0);
        check_val("rmf_fetch_inst", out_fetcher_inst, 32'd0);
        check_val("rmf_mem_flag", 32'(out_mem_flag), 32'd0);
        check_val("rmf_mem_addr", out_mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc;
        int          xbp, stl;
        rst             = 1'b1;
        rdy             = 1'b1;
        in_fetcher_flag = 1'b0;
        in_fetcher_pc   = '0;
        in_rob_xbp      = 1'b0;
        in_mem_flag     = 1'b0;
        in_mem_data     = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check_val("rst_fetch_flag", 32'(out_fetcher_flag), 32'd0);
        check_val("rst_fetch_inst", out_fetcher_inst, 32'd0);
        check_val("rst_mem_flag", 32'(out_mem_flag), 32'd0);
        check_val("rst_mem_addr", out_mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_fetch(32'h0000_0000, -1, -1);
        do_fetch(32'h0000_0008, -1, -1);
        do_fetch(32'h0000_0400, -1, -1);
        do_fetch(32'h0000_0000, -1, -1);
        do_fetch(32'h0000_000C, -1, -1);
        do_fetch(32'h0000_0010, 1, -1);
        do_fetch(32'h0000_0014, -1, -1);
        reset_mid_fill(32'h0000_0020);
        do_fetch(32'h0000_0020, -1, -1);
        do_fetch(32'h0000_0034, -1, 2);
        do_fetch(32'h0000_0030, -1, 0);
        req_with_xbp(32'h0000_0040);
        req_with_xbp(32'h0000_0030);
        do_fetch(32'hFFFF_FFFC, -1, -1);
        do_fetch(32'hFFFF_FFF3, -1, -1);

        for (int i = 0; i < 120; i++) begin
            pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            xbp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
            stl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 9) == 0) begin
                req_with_xbp(pc);
            end else begin
                do_fetch(pc, xbp, stl);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
